// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller in front of the datapath ALU: decodes ALUOp/funct, issues from S1, captures into S2.
// Build option ALU_NOR_EN: when defined, R-type funct 100111 decodes to NOR (1100) instead of illegal.
module alu_issue_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_branch_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  logic [3:0]       dec_ctl;
  logic             dec_br;
  logic             dec_ill;

  logic             s1_valid_q;
  logic [3:0]       s1_ctl_q;
  logic [31:0]      s1_a_q;
  logic [31:0]      s1_b_q;
  logic             s1_br_q;
  logic             s1_ill_q;

  logic             s2_valid_q;
  logic [31:0]      s2_res_q;
  logic             s2_zero_q;
  logic             s2_br_q;
  logic             s2_ill_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic [31:0]      s2_res_d;
  logic             s2_zero_d;
  logic             s2_br_d;
  logic             cnt_inc;

  always_comb begin
    dec_ctl = 4'b1111;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    case (in_aluop)
      2'b00: dec_ctl = 4'b0010;
      2'b01: begin
        dec_ctl = 4'b0110;
        dec_br  = 1'b1;
      end
      2'b10: begin
        case (in_funct)
          6'b100000: dec_ctl = 4'b0010;
          6'b100010: dec_ctl = 4'b0110;
          6'b100100: dec_ctl = 4'b0000;
          6'b100101: dec_ctl = 4'b0001;
          6'b101010: dec_ctl = 4'b0111;
`ifdef ALU_NOR_EN
          6'b100111: dec_ctl = 4'b1100;
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;
    cnt_inc  = s2_valid_q && out_ready && s2_ill_q && (cnt_q != '1);
    // Illegal ops are forced here so the ALU output is otherwise a straight wire into S2.
    s2_res_d  = s1_ill_q ? '0   : alu_result;
    s2_zero_d = s1_ill_q ? 1'b1 : alu_zero;
    s2_br_d   = s1_br_q && !s1_ill_q && alu_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_ctl_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_br_q    <= 1'b0;
      s1_ill_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_zero_q  <= 1'b0;
      s2_br_q    <= 1'b0;
      s2_ill_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_ctl_q   <= dec_ctl;
        s1_a_q     <= in_a;
        s1_b_q     <= in_b;
        s1_br_q    <= dec_br;
        s1_ill_q   <= dec_ill;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid_q <= 1'b1;
        s2_res_q   <= s2_res_d;
        s2_zero_q  <= s2_zero_d;
        s2_br_q    <= s2_br_d;
        s2_ill_q   <= s1_ill_q;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign alu_a            = s1_a_q;
  assign alu_b            = s1_b_q;
  assign alu_ctl          = s1_ctl_q;
  assign out_valid        = s2_valid_q;
  assign out_result       = s2_res_q;
  assign out_zero         = s2_zero_q;
  assign out_branch_taken = s2_br_q;
  assign out_illegal      = s2_ill_q;
  assign illegal_count    = cnt_q;

endmodule
